// File: rtl/reg_to_axi_wide_pkg.sv
// Shared types for the Regbus-to-wide-AXI4 bridge: FSM states, AXI encodings,
// lane-index width helper and default bus structs (32-bit Regbus, 64-bit AXI).
package reg_to_axi_wide_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AR     = 3'd1,
    R_WAIT = 3'd2,
    AWW    = 3'd3,
    B_WAIT = 3'd4,
    DRAIN  = 3'd5
  } state_e;

  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;
  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;

  // Lane index is at least one bit wide so equal-width builds still have a legal vector.
  function automatic int unsigned lane_idx_width(input int unsigned reg_dw,
                                                 input int unsigned axi_dw);
    return (axi_dw > reg_dw) ? $clog2(axi_dw / reg_dw) : 1;
  endfunction

  localparam int unsigned DefRegAw  = 32;
  localparam int unsigned DefRegDw  = 32;
  localparam int unsigned DefAxiAw  = 64;
  localparam int unsigned DefAxiDw  = 64;
  localparam int unsigned DefAxiIdw = 4;

  typedef struct packed {
    logic [DefRegAw-1:0]   addr;
    logic                  write;
    logic [DefRegDw-1:0]   wdata;
    logic [DefRegDw/8-1:0] wstrb;
    logic                  valid;
  } reg_req_default_t;

  typedef struct packed {
    logic [DefRegDw-1:0] rdata;
    logic                error;
    logic                ready;
  } reg_rsp_default_t;

  typedef struct packed {
    logic [DefAxiIdw-1:0] id;
    logic [DefAxiAw-1:0]  addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
  } axi_ax_default_t;

  typedef struct packed {
    logic [DefAxiDw-1:0]   data;
    logic [DefAxiDw/8-1:0] strb;
    logic                  last;
  } axi_w_default_t;

  typedef struct packed {
    logic [DefAxiIdw-1:0] id;
    logic [1:0]           resp;
  } axi_b_default_t;

  typedef struct packed {
    logic [DefAxiIdw-1:0] id;
    logic [DefAxiDw-1:0]  data;
    logic [1:0]           resp;
    logic                 last;
  } axi_r_default_t;

  typedef struct packed {
    axi_ax_default_t aw;
    logic            aw_valid;
    axi_w_default_t  w;
    logic            w_valid;
    logic            b_ready;
    axi_ax_default_t ar;
    logic            ar_valid;
    logic            r_ready;
  } axi_req_default_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    axi_b_default_t b;
    logic           r_valid;
    axi_r_default_t r;
  } axi_rsp_default_t;

endpackage

// File: rtl/reg_to_axi_lane_steer.sv
// Combinational lane steering between a narrow Regbus word and a wide AXI beat:
// write data replication, strobe placement and read lane extraction.
module reg_to_axi_lane_steer
  import reg_to_axi_wide_pkg::*;
#(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  localparam int unsigned Ratio       = AxiDataWidth / RegDataWidth,
  localparam int unsigned LaneW       = lane_idx_width(RegDataWidth, AxiDataWidth),
  localparam int unsigned RegStrbW    = RegDataWidth / 8,
  localparam int unsigned AxiStrbW    = AxiDataWidth / 8
) (
  input  logic [LaneW-1:0]        lane,
  input  logic [RegDataWidth-1:0] reg_wdata,
  input  logic [RegStrbW-1:0]     reg_wstrb,
  input  logic [AxiDataWidth-1:0] axi_rdata,
  output logic [AxiDataWidth-1:0] axi_wdata,
  output logic [AxiStrbW-1:0]     axi_wstrb,
  output logic [RegDataWidth-1:0] reg_rdata
);

  always_comb begin
    axi_wdata = {Ratio{reg_wdata}};
    axi_wstrb = '0;
    reg_rdata = '0;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (lane == LaneW'(i)) begin
        axi_wstrb[i*RegStrbW +: RegStrbW]   = reg_wstrb;
        reg_rdata                           = axi_rdata[i*RegDataWidth +: RegDataWidth];
      end
    end
  end

endmodule

// File: rtl/reg_to_axi_wide.sv
// Regbus-to-AXI4 bridge with lane steering onto a wider AXI bus, one transaction in flight.
// Optional response timeout with a DRAIN state is enabled by defining REG_TO_AXI_TIMEOUT_EN.
module reg_to_axi_wide
  import reg_to_axi_wide_pkg::*;
#(
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned AxiIdWidth    = 4,
  parameter int unsigned AxiId         = 0,
  parameter logic [3:0]  AxiCache      = CACHE_MODIFIABLE,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type reg_req_t = reg_req_default_t,
  parameter type reg_rsp_t = reg_rsp_default_t,
  parameter type axi_req_t = axi_req_default_t,
  parameter type axi_rsp_t = axi_rsp_default_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output axi_req_t axi_req_o,
  input  axi_rsp_t axi_rsp_i,
  output logic     busy_o,
  output logic     timeout_o,
  output state_e   state_o
);

  localparam int unsigned RegOffW = $clog2(RegDataWidth / 8);
  localparam int unsigned LaneW   = lane_idx_width(RegDataWidth, AxiDataWidth);

  state_e                    state_q;
  logic [RegAddrWidth-1:0]   addr_q;
  logic [LaneW-1:0]          lane_q, lane_d;
  logic                      write_q;
  logic [RegDataWidth-1:0]   wdata_q;
  logic [RegDataWidth/8-1:0] wstrb_q;
  logic                      aw_done_q, w_done_q;

  logic ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_fin, w_fin;
  logic timeout_hit;

  logic [AxiDataWidth-1:0]   axi_wdata;
  logic [AxiDataWidth/8-1:0] axi_wstrb;
  logic [RegDataWidth-1:0]   lane_rdata;

  // Handshake rule on every AXI channel: a transfer happens in the cycle where
  // valid and ready are both high; a raised valid stays high until that cycle.
  assign ar_hs  = ar_valid & axi_rsp_i.ar_ready;
  assign aw_hs  = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs   = w_valid  & axi_rsp_i.w_ready;
  assign r_hs   = r_ready  & axi_rsp_i.r_valid;
  assign b_hs   = b_ready  & axi_rsp_i.b_valid;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q  | w_hs;

  if (AxiDataWidth > RegDataWidth) begin : g_lane
    assign lane_d = LaneW'(reg_req_i.addr >> RegOffW);
  end else begin : g_no_lane
    assign lane_d = '0;
  end

  reg_to_axi_lane_steer #(
    .RegDataWidth (RegDataWidth),
    .AxiDataWidth (AxiDataWidth)
  ) u_lane_steer (
    .lane      (lane_q),
    .reg_wdata (wdata_q),
    .reg_wstrb (wstrb_q),
    .axi_rdata (axi_rsp_i.r.data),
    .axi_wdata (axi_wdata),
    .axi_wstrb (axi_wstrb),
    .reg_rdata (lane_rdata)
  );

`ifdef REG_TO_AXI_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] cnt_q;
  logic            ar_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || state_q == DRAIN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A response arriving in the expiry cycle still completes normally.
  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1)) &&
                       (state_q != IDLE) && (state_q != DRAIN) &&
                       !(state_q == R_WAIT && r_hs) && !(state_q == B_WAIT && b_hs);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lane_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef REG_TO_AXI_TIMEOUT_EN
      ar_done_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (reg_req_i.valid) begin
            addr_q  <= reg_req_i.addr;
            lane_q  <= lane_d;
            write_q <= reg_req_i.write;
            wdata_q <= reg_req_i.wdata;
            wstrb_q <= reg_req_i.wstrb;
            state_q <= reg_req_i.write ? AWW : AR;
          end
        end
        AR:     if (ar_hs) state_q <= R_WAIT;
        R_WAIT: if (r_hs)  state_q <= IDLE;
        AWW: begin
          if (aw_fin && w_fin) begin
            state_q   <= B_WAIT;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
          end
        end
        B_WAIT: if (b_hs) state_q <= IDLE;
`ifdef REG_TO_AXI_TIMEOUT_EN
        DRAIN: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (write_q ? b_hs : r_hs) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
`ifdef REG_TO_AXI_TIMEOUT_EN
      // Remember which address/data beats already went out so DRAIN only finishes the rest.
      if (timeout_hit) begin
        state_q   <= DRAIN;
        ar_done_q <= (state_q == R_WAIT) || ar_hs;
        aw_done_q <= (state_q == B_WAIT) || aw_fin;
        w_done_q  <= (state_q == B_WAIT) || w_fin;
      end
`endif
    end
  end

  always_comb begin
    ar_valid = (state_q == AR);
    r_ready  = (state_q == R_WAIT);
    aw_valid = (state_q == AWW) && !aw_done_q;
    w_valid  = (state_q == AWW) && !w_done_q;
    b_ready  = (state_q == B_WAIT);
`ifdef REG_TO_AXI_TIMEOUT_EN
    if (state_q == DRAIN) begin
      ar_valid = !write_q && !ar_done_q;
      aw_valid = write_q && !aw_done_q;
      w_valid  = write_q && !w_done_q;
      r_ready  = 1'b1;
      b_ready  = 1'b1;
    end
`endif
  end

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.ar.id     = AxiIdWidth'(AxiId);
    axi_req_o.ar.addr   = AxiAddrWidth'(addr_q);
    axi_req_o.ar.size   = 3'(RegOffW);
    axi_req_o.ar.burst  = BURST_INCR;
    axi_req_o.ar.cache  = AxiCache;
    axi_req_o.aw.id     = AxiIdWidth'(AxiId);
    axi_req_o.aw.addr   = AxiAddrWidth'(addr_q);
    axi_req_o.aw.size   = 3'(RegOffW);
    axi_req_o.aw.burst  = BURST_INCR;
    axi_req_o.aw.cache  = AxiCache;
    axi_req_o.w.data    = axi_wdata;
    axi_req_o.w.strb    = axi_wstrb;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.ar_valid  = ar_valid;
    axi_req_o.aw_valid  = aw_valid;
    axi_req_o.w_valid   = w_valid;
    axi_req_o.r_ready   = r_ready;
    axi_req_o.b_ready   = b_ready;
  end

  always_comb begin
    reg_rsp_o = '0;
    if (state_q == R_WAIT && r_hs) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = lane_rdata;
      reg_rsp_o.error = (axi_rsp_i.r.resp != RESP_OKAY);
    end
    if (state_q == B_WAIT && b_hs) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = (axi_rsp_i.b.resp != RESP_OKAY);
    end
    if (timeout_hit) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = 1'b1;
      reg_rsp_o.rdata = '0;
    end
  end

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.r.id, axi_rsp_i.r.last, axi_rsp_i.b.id};

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_hit;
  assign state_o   = state_q;

endmodule
